// File: rtl/conv1d_stream.sv
// Streaming 1-D FIR convolution engine: TAPS programmable coefficients, valid or
// causal zero-padded mode, shift-and-saturate output with full-throughput handshakes.
module conv1d_stream #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int LEN_W  = 16,
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS),
  localparam int SH_W  = $clog2(ACC_W),
  localparam int IDX_W = $clog2(TAPS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [SH_W-1:0]   shift_i,
  input  logic              coef_we_i,
  input  logic [IDX_W-1:0]  coef_idx_i,
  input  logic [COEF_W-1:0] coef_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              busy_o,
  output logic              done_int_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t state_reg, state_next;

  logic signed [COEF_W-1:0] coef_reg  [TAPS];
  logic signed [DATA_W-1:0] dline_reg [TAPS-1];
  logic signed [DATA_W-1:0] tap_x     [TAPS];
  logic signed [ACC_W-1:0]  prod      [TAPS];
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_shift;
  logic signed [DATA_W-1:0] sat_data;

  logic              mode_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  cnt_reg;
  logic [SH_W-1:0]   shift_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              done_int_reg;

  logic in_fire;
  logic out_fire;
  logic last_in;
  logic emit;

  // A slot frees up when the held output is absent or leaving this cycle.
  assign out_fire   = out_valid_reg && out_ready_i;
  assign in_ready_o = (state_reg == RUN) && (cnt_reg < len_reg) &&
                      (!out_valid_reg || out_ready_i);
  assign in_fire    = in_ready_o && in_valid_i;
  assign last_in    = in_fire && (cnt_reg == len_reg - LEN_W'(1));
  assign emit       = mode_reg || (cnt_reg >= LEN_W'(TAPS - 1));

  assign out_valid_o = out_valid_reg;
  assign out_data_o  = out_data_reg;
  assign busy_o      = (state_reg != IDLE);
  assign done_int_o  = done_int_reg;

  // Tap 0 is the incoming sample itself, so the result is ready on the accept edge.
  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign tap_x[gi] = in_data_i;
      end else begin : g_dly
        assign tap_x[gi] = dline_reg[gi-1];
      end
      assign prod[gi] = ACC_W'(coef_reg[gi]) * ACC_W'(tap_x[gi]);
    end
  endgenerate

  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc_sum = acc_sum + prod[k];
    end
  end

  always_comb begin
    acc_shift = acc_sum >>> shift_reg;
    sat_data  = acc_shift[DATA_W-1:0];
    if (acc_shift > SAT_MAX) begin
      sat_data = SAT_MAX[DATA_W-1:0];
    end else if (acc_shift < SAT_MIN) begin
      sat_data = SAT_MIN[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = (len_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (last_in) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid_reg || out_ready_i) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_reg      <= 1'b0;
      len_reg       <= '0;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      done_int_reg  <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        coef_reg[k] <= '0;
      end
      for (int k = 0; k < TAPS - 1; k++) begin
        dline_reg[k] <= '0;
      end
    end else begin
      done_int_reg <= (state_reg == DONE);

      if (state_reg == IDLE) begin
        if (coef_we_i && (int'(coef_idx_i) < TAPS)) begin
          coef_reg[coef_idx_i] <= coef_data_i;
        end
        if (start_i) begin
          mode_reg  <= mode_i;
          len_reg   <= len_i;
          shift_reg <= shift_i;
          cnt_reg   <= '0;
          for (int k = 0; k < TAPS - 1; k++) begin
            dline_reg[k] <= '0;
          end
        end
      end

      if (in_fire) begin
        dline_reg[0] <= in_data_i;
        for (int k = 1; k < TAPS - 1; k++) begin
          dline_reg[k] <= dline_reg[k-1];
        end
        cnt_reg <= cnt_reg + LEN_W'(1);
      end

      // A new result replaces a departing one in the same cycle.
      if (in_fire && emit) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= sat_data;
      end else if (out_fire) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv1d_stream.sv
// Scoreboard bench for conv1d_stream (TAPS=4): directed jobs push expected outputs,
// an independent monitor pops and compares on every output transfer.
module tb_conv1d_stream;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int TP = 4;
  localparam int LW = 16;
  localparam int AW = DW + CW + $clog2(TP);
  localparam int SW = $clog2(AW);
  localparam int IW = $clog2(TP);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [LW-1:0] len;
  logic [SW-1:0] shift;
  logic          coef_we;
  logic [IW-1:0] coef_idx;
  logic [CW-1:0] coef_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done_int;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int h_model [TP];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_val;

  conv1d_stream #(.DATA_W(DW), .COEF_W(CW), .TAPS(TP), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .len_i(len),
    .shift_i(shift), .coef_we_i(coef_we), .coef_idx_i(coef_idx),
    .coef_data_i(coef_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .busy_o(busy), .done_int_o(done_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge when both sides are high here.
  always @(negedge clk) begin
    if (!rst && done_int) done_cnt++;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h required no output", out_data);
      end else begin
        exp_val = exp_q.pop_front();
        check("out_data", {16'd0, out_data}, {16'd0, exp_val});
        $display("out y=%0d expected=%0d", $signed(out_data), $signed(exp_val));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_h(input int a, input int b, input int c, input int d);
    int v [TP];
    v = '{a, b, c, d};
    for (int k = 0; k < TP; k++) begin
      coef_we   = 1'b1;
      coef_idx  = IW'(k);
      coef_data = CW'(v[k]);
      h_model[k] = v[k];
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic start_job(input logic m, input int n, input int sh);
    start = 1'b1;
    mode  = m;
    len   = LW'(n);
    shift = SW'(sh);
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int xs[$], output int cycles);
    int i;
    logic acc;
    i = 0;
    cycles = 0;
    while (i < xs.size() && cycles < 200) begin
      in_valid = 1'b1;
      in_data  = DW'(xs[i]);
      @(negedge clk);
      acc = in_ready;
      tick();
      cycles++;
      if (acc) i++;
    end
    in_valid = 1'b0;
    check("feed_complete", i, xs.size());
  endtask

  task automatic finish_job(input int d0, input string name);
    for (int w = 0; w < 50 && done_cnt == d0; w++) tick();
    tick();
    tick();
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    check({name, "_leftover"}, exp_q.size(), 0);
    $display("job %s finished", name);
  endtask

  task automatic run_job(input logic m, input int sh, input int xs[$], input string name);
    int d0;
    int cyc;
    d0 = done_cnt;
    start_job(m, xs.size(), sh);
    feed(xs, cyc);
    check({name, "_cycles"}, cyc, xs.size());
    finish_job(d0, name);
  endtask

  function automatic void push_model(input logic m, input int sh, input int xs[$]);
    longint acc;
    for (int n = 0; n < xs.size(); n++) begin
      acc = 0;
      for (int k = 0; k < TP; k++) begin
        if (n - k >= 0) acc += longint'(h_model[k]) * longint'(xs[n-k]);
      end
      acc = acc >>> sh;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      if (m || n >= TP - 1) exp_q.push_back(DW'(acc));
    end
  endfunction

  initial begin
    int cyc;
    int d0;
    int xs [$];
    rst = 1'b1; start = 1'b0; mode = 1'b0; len = '0; shift = '0;
    coef_we = 1'b0; coef_idx = '0; coef_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_int, 0);
    rst = 1'b0;
    tick();

    set_h(1, 2, 3, 4);
    exp_q.push_back(16'd1); exp_q.push_back(16'd3); exp_q.push_back(16'd6);
    exp_q.push_back(16'd10); exp_q.push_back(16'd10);
    run_job(1'b1, 0, '{1, 1, 1, 1, 1}, "causal_ones");

    exp_q.push_back(16'd20); exp_q.push_back(16'd30);
    run_job(1'b0, 0, '{1, 2, 3, 4, 5}, "valid_n5");

    run_job(1'b0, 0, '{1, 2, 3}, "valid_n3");

    set_h(32767, 0, 0, 0);
    exp_q.push_back(16'h7FFF); exp_q.push_back(16'h8000);
    run_job(1'b1, 0, '{32767, -32768}, "saturate");

    set_h(16384, 0, 0, 0);
    exp_q.push_back(16'h2000); exp_q.push_back(16'hE000);
    run_job(1'b1, 15, '{16384, -16384}, "shift15");

    // Zero-length job: DONE next cycle, pulse one cycle later.
    d0 = done_cnt;
    start_job(1'b0, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("len0_in_ready", in_ready, 0);
      check("len0_done_timing", done_int, (c == 2) ? 1 : 0);
      tick();
    end
    check("len0_done_pulses", done_cnt - d0, 1);

    // start/coef writes during RUN must not disturb the job.
    set_h(1, 2, 3, 4);
    exp_q.push_back(16'd1); exp_q.push_back(16'd3); exp_q.push_back(16'd6);
    exp_q.push_back(16'd10); exp_q.push_back(16'd10);
    d0 = done_cnt;
    start_job(1'b1, 5, 0);
    fork
      feed('{1, 1, 1, 1, 1}, cyc);
      begin
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; len = '0; mode = 1'b0;
        coef_we = 1'b1; coef_idx = '0; coef_data = CW'(100);
        tick();
        start = 1'b0; coef_we = 1'b0;
      end
    join
    check("ignore_cycles", cyc, 5);
    finish_job(d0, "ignore_in_run");

    // Backpressure: 5 stalled cycles mid-stream, then full rate again.
    xs = '{3, -2, 7, 100, -50, 1, 0, 9, -9, 4};
    push_model(1'b1, 0, xs);
    d0 = done_cnt;
    start_job(1'b1, xs.size(), 0);
    fork
      feed(xs, cyc);
      begin
        logic [DW-1:0] held;
        held = '0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          if (j == 0) held = out_data;
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          check("stall_out_data", out_data, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check("stall_cycles", cyc, xs.size() + 5);
    finish_job(d0, "stall");

    // Reset mid-job after 3 of 10 samples.
    exp_q.push_back(16'd1); exp_q.push_back(16'd3); exp_q.push_back(16'd6);
    start_job(1'b1, 10, 0);
    feed('{1, 1, 1}, cyc);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("abort_no_done", done_cnt - d0, 0);

    exp_q.push_back(16'd0); exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    run_job(1'b1, 0, '{5, 6, 7}, "coefs_cleared");

    set_h(1, 2, 3, 4);
    exp_q.push_back(16'd20); exp_q.push_back(16'd30);
    run_job(1'b0, 0, '{1, 2, 3, 4, 5}, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
